// File: rtl/full_cpu_top_if.sv
// Board-level I/O bundle for full_cpu_top: CPU controls, UART line, 7-seg and LED outputs.
// The master side is the CPU design, the slave side is the board or testbench.
`timescale 1ns/1ps
interface full_cpu_top_if;
  logic [2:0]  clk_speed;
  logic        clk_visual;
  logic        UART_rx;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] led;

  modport master (input clk_speed, clk_visual, UART_rx, output seg, an, led);
  modport slave  (output clk_speed, clk_visual, UART_rx, input seg, an, led);
endinterface

// File: rtl/full_cpu_top.sv
// 8-bit single-cycle CPU. Programs arrive as 3-byte words over a UART loader,
// execution runs at a selectable step rate, and PC/OUT/IMEM appear on a 4-digit 7-seg and the LEDs.
`timescale 1ns/1ps
module full_cpu_top #(
  parameter int BAUD_DIV     = 868,
  parameter int REFRESH_BITS = 18,
  parameter int IMEM_AW      = 8
) (
  input  logic clk,
  input  logic rst,
  full_cpu_top_if.master io
);

  localparam int CW = $clog2(BAUD_DIV) + 1;
  localparam logic [CW-1:0] BAUD_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [23:0] W_LOAD    = 24'hFF0000;
  localparam logic [23:0] W_RUN_RST = 24'hFFFF00;
  localparam logic [23:0] W_RUN     = 24'hFFF000;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_RUN} ld_state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_NOT,
    OP_LDI, OP_ADDI, OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_NOP, OP_JMP
  } op_e;

  // ---------------- UART receiver ----------------
  logic            rx_meta, rx_s, rx_prev;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {rx_meta, rx_s, rx_prev} <= 3'b111;
      rx_state_q   <= RX_IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      rx_meta      <= io.UART_rx;
      rx_s         <= rx_meta;
      rx_prev      <= rx_s;
      rx_state_q   <= rx_state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rx_state_d   = rx_state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_prev && !rx_s) begin
        rx_state_d = RX_START;
        baud_d     = '0;
      end
      RX_START: if (baud_q == HALF_M1) begin
        // Recheck mid start bit; a short glitch falls back to idle.
        baud_d     = '0;
        bit_d      = '0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end else baud_d = baud_q + CW'(1);
      RX_DATA: if (baud_q == BAUD_M1) begin
        baud_d  = '0;
        shift_d = {rx_s, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) rx_state_d = RX_STOP;
      end else baud_d = baud_q + CW'(1);
      RX_STOP: if (baud_q == BAUD_M1) begin
        byte_valid_d = rx_s;
        rx_state_d   = RX_IDLE;
      end else baud_d = baud_q + CW'(1);
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Word assembly ----------------
  logic [1:0]  byte_cnt_q;
  logic [7:0]  w0_q, w1_q;
  logic [23:0] word_q;
  logic        word_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q   <= '0;
      w0_q         <= '0;
      w1_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= 1'b0;
      if (byte_valid_q) begin
        case (byte_cnt_q)
          2'd0:    begin w0_q <= shift_q; byte_cnt_q <= 2'd1; end
          2'd1:    begin w1_q <= shift_q; byte_cnt_q <= 2'd2; end
          default: begin
            word_q       <= {shift_q, w1_q, w0_q};
            word_valid_q <= 1'b1;
            byte_cnt_q   <= 2'd0;
          end
        endcase
      end
    end
  end

  // ---------------- Loader FSM ----------------
  ld_state_e          ld_q, ld_d;
  logic [IMEM_AW-1:0] waddr_q, waddr_d;
  logic               imem_we, cpu_clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_q    <= LD_IDLE;
      waddr_q <= '0;
    end else begin
      ld_q    <= ld_d;
      waddr_q <= waddr_d;
    end
  end

  always_comb begin
    ld_d      = ld_q;
    waddr_d   = waddr_q;
    imem_we   = 1'b0;
    cpu_clear = 1'b0;
    case (ld_q)
      LD_IDLE: if (word_valid_q && word_q == W_LOAD) begin
        ld_d    = LD_LOAD;
        waddr_d = '0;
      end
      LD_LOAD: if (word_valid_q) begin
        if (word_q == W_RUN_RST) begin
          ld_d      = LD_RUN;
          cpu_clear = 1'b1;
        end else if (word_q == W_RUN) begin
          ld_d = LD_RUN;
        end else if (word_q == W_LOAD) begin
          waddr_d = '0;
        end else begin
          imem_we = 1'b1;
          waddr_d = waddr_q + IMEM_AW'(1);
        end
      end
      LD_RUN: if (word_valid_q && word_q == W_LOAD) begin
        ld_d    = LD_LOAD;
        waddr_d = '0;
      end
      default: ld_d = LD_IDLE;
    endcase
  end

  // ---------------- Step-rate divider ----------------
  logic [26:0] div_q;
  logic [26:0] step_mask;
  logic [4:0]  shamt;
  logic        step_en, cpu_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_q + 27'd1;
  end

  // One step every 2^(3n+6) cycles; n=7 shifts out to zero, which still yields an all-ones mask.
  always_comb begin
    shamt     = 5'(io.clk_speed) * 5'd3 + 5'd6;
    step_mask = (27'd1 << shamt) - 27'd1;
    step_en   = (io.clk_speed == 3'd0) || ((div_q & step_mask) == step_mask);
    cpu_run   = (ld_q == LD_RUN) && step_en;
  end

  // ---------------- Core ----------------
  logic [23:0]        imem [2**IMEM_AW];
  logic [7:0]         dmem [2**IMEM_AW];
  logic [7:0]         rf   [16];
  logic [IMEM_AW-1:0] pc_q, pc_next;
  logic [7:0]         out_q;
  logic [23:0]        instr;
  op_e                op;
  logic [7:0]         ra, rb, imm, wb_val;
  logic [3:0]         rd_idx;
  logic               wb_en, st_en;

  always_comb begin
    instr   = imem[pc_q];
    op      = op_e'(instr[23:20]);
    ra      = rf[instr[19:16]];
    rb      = rf[instr[15:12]];
    rd_idx  = instr[11:8];
    imm     = instr[7:0];
    wb_en   = 1'b0;
    wb_val  = '0;
    st_en   = 1'b0;
    pc_next = pc_q + IMEM_AW'(1);
    case (op)
      OP_ADD:  begin wb_en = 1'b1; wb_val = ra + rb;             end
      OP_SUB:  begin wb_en = 1'b1; wb_val = ra - rb;             end
      OP_AND:  begin wb_en = 1'b1; wb_val = ra & rb;             end
      OP_OR:   begin wb_en = 1'b1; wb_val = ra | rb;             end
      OP_XOR:  begin wb_en = 1'b1; wb_val = ra ^ rb;             end
      OP_SHL:  begin wb_en = 1'b1; wb_val = {ra[6:0], 1'b0};     end
      OP_SHR:  begin wb_en = 1'b1; wb_val = {1'b0, ra[7:1]};     end
      OP_NOT:  begin wb_en = 1'b1; wb_val = ~ra;                 end
      OP_LDI:  begin wb_en = 1'b1; wb_val = imm;                 end
      OP_ADDI: begin wb_en = 1'b1; wb_val = ra + imm;            end
      OP_LD:   begin wb_en = 1'b1; wb_val = dmem[IMEM_AW'(imm)]; end
      OP_ST:   st_en = 1'b1;
      OP_BEQ:  if (ra == rb) pc_next = IMEM_AW'(imm);
      OP_BNE:  if (ra != rb) pc_next = IMEM_AW'(imm);
      OP_JMP:  pc_next = IMEM_AW'(imm);
      default: ;
    endcase
  end

  // r0 is never written, so it always reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      out_q <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (cpu_clear) begin
      pc_q  <= '0;
      out_q <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (cpu_run) begin
      pc_q <= pc_next;
      if (wb_en && rd_idx != 4'd0) rf[rd_idx] <= wb_val;
      if (st_en) out_q <= rb;
    end
  end

  // NOTE: memories carry no reset so they map onto RAM; their contents survive rst.
  always_ff @(posedge clk) begin
    if (imem_we) imem[waddr_q] <= word_q;
  end

  always_ff @(posedge clk) begin
    if (cpu_run && st_en) dmem[IMEM_AW'(imm)] <= rb;
  end

  // ---------------- Display ----------------
  logic [REFRESH_BITS-1:0] ref_q;
  logic [1:0]              sel;
  logic [15:0]             disp_val;
  logic [3:0]              digit;
  logic [6:0]              seg_q;
  logic [3:0]              an_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    sel      = ref_q[REFRESH_BITS-1 -: 2];
    disp_val = io.clk_visual ? imem[pc_q][15:0] : {8'(pc_q), out_q};
    digit    = disp_val[{sel, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_q <= '0;
      seg_q <= 7'h7F;
      an_q  <= 4'hF;
    end else begin
      ref_q <= ref_q + REFRESH_BITS'(1);
      seg_q <= hex7(digit);
      an_q  <= ~(4'b0001 << sel);
    end
  end

  assign io.seg = seg_q;
  assign io.an  = an_q;
  assign io.led = {out_q, 8'(pc_q)};

endmodule

// File: tb/tb_full_cpu_top.sv
// Directed bench for full_cpu_top: UART-loaded programs from a vector table, then
// hand-written sequences for trace, step rate, reset, framing errors and display scan.
`timescale 1ns/1ps
module tb_full_cpu_top;
  localparam int BAUD = 16;
  localparam int RB   = 6;   // each digit is active for 2^(RB-2) = 16 cycles

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  full_cpu_top_if bif ();
  full_cpu_top #(.BAUD_DIV(BAUD), .REFRESH_BITS(RB), .IMEM_AW(8)) dut (
    .clk(clk),
    .rst(rst),
    .io (bif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [23:0] word;
    logic        chk;
    logic [15:0] exp_led;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } scan_t;

  vec_t       vecs [27];
  scan_t      scan [4];
  logic [7:0] trace_exp [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    bif.UART_rx = v;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    bif.UART_rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
  endtask

  task automatic send_word(input logic [23:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte(w[15:8], 1'b1);
    send_byte(w[23:16], 1'b1);
  endtask

  // Leaves the bench 8 cycles into an an=E phase, i.e. mid-digit.
  task automatic sync_scan();
    int t = 0;
    while (bif.an == 4'hE && t < 200) begin @(negedge clk); t++; end
    t = 0;
    while (bif.an != 4'hE && t < 200) begin @(negedge clk); t++; end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int         t;
    int         changes;
    int         first_i, second_i;
    logic [7:0] prev;

    // Program 1: store 0x10 to OUT and DMEM[0], park at 2.
    vecs[0]  = '{24'hFF0000, 1'b0, 16'h0000};
    vecs[1]  = '{24'h800110, 1'b0, 16'h0000};
    vecs[2]  = '{24'hB01000, 1'b0, 16'h0000};
    vecs[3]  = '{24'hF00002, 1'b0, 16'h0000};
    vecs[4]  = '{24'hFFFF00, 1'b1, 16'h1002};
    // Program 2: r2 = DMEM[0] = 0x10, both BEQs fall through, park at 4; OUT cleared.
    vecs[5]  = '{24'hFF0000, 1'b0, 16'h0000};
    vecs[6]  = '{24'h800200, 1'b0, 16'h0000};
    vecs[7]  = '{24'hA00200, 1'b0, 16'h0000};
    vecs[8]  = '{24'hC20001, 1'b0, 16'h0000};
    vecs[9]  = '{24'hC12001, 1'b0, 16'h0000};
    vecs[10] = '{24'hF00004, 1'b0, 16'h0000};
    vecs[11] = '{24'hF00003, 1'b0, 16'h0000};
    vecs[12] = '{24'hFFFF00, 1'b1, 16'h0004};
    // Program 3, resumed without CPU reset from PC=4.
    vecs[13] = '{24'hFF0000, 1'b0, 16'h0000};
    for (int i = 14; i < 19; i++) vecs[i] = '{24'hF00006, 1'b0, 16'h0000};
    vecs[19] = '{24'h800105, 1'b0, 16'h0000};
    vecs[20] = '{24'h800206, 1'b0, 16'h0000};
    vecs[21] = '{24'h012300, 1'b0, 16'h0000};
    vecs[22] = '{24'h80040B, 1'b0, 16'h0000};
    vecs[23] = '{24'hC34001, 1'b0, 16'h0000};
    vecs[24] = '{24'hF00001, 1'b0, 16'h0000};
    vecs[25] = '{24'hF00002, 1'b0, 16'h0000};
    vecs[26] = '{24'hFFF000, 1'b0, 16'h0000};

    // Display {PC=02, OUT=A0} -> digits right to left 0, A, 2, 0.
    scan[0] = '{4'hE, 7'h40};
    scan[1] = '{4'hD, 7'h08};
    scan[2] = '{4'hB, 7'h24};
    scan[3] = '{4'h7, 7'h40};

    // Address 5 is never executed, r1 stays 0, so r3=6 != r4=0x0B and BEQ falls through.
    trace_exp = '{8'd7, 8'd8, 8'd9, 8'd10, 8'd1, 8'd6};

    bif.clk_speed  = 3'd0;
    bif.clk_visual = 1'b0;
    bif.UART_rx    = 1'b1;

    repeat (5) @(negedge clk);
    check("reset_seg", 32'(bif.seg), 32'h7F);
    check("reset_an",  32'(bif.an),  32'hF);
    check("reset_led", 32'(bif.led), 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 27; i++) begin
      send_word(vecs[i].word);
      if (vecs[i].chk) begin
        repeat (40) @(negedge clk);
        check($sformatf("prog_led_%0d", i), 32'(bif.led), 32'(vecs[i].exp_led));
      end
    end

    t = 0;
    while (bif.led[7:0] != 8'h06 && t < 100) begin @(negedge clk); t++; end
    check("trace_reach_6", 32'(bif.led[7:0]), 32'h06);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("trace_pc_%0d", k), 32'(bif.led[7:0]), 32'(trace_exp[k]));
    end
    check("trace_out", 32'(bif.led[15:8]), 32'h00);

    // clk_speed=1: the loop never jumps to itself, so every step moves the PC.
    bif.clk_speed = 3'd1;
    prev     = bif.led[7:0];
    changes  = 0;
    first_i  = -1;
    second_i = -1;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (bif.led[7:0] != prev) begin
        changes++;
        if (first_i < 0) first_i = i;
        else if (second_i < 0) second_i = i;
      end
      prev = bif.led[7:0];
    end
    check("speed1_steps",  32'(changes), 32'd4);
    check("speed1_period", 32'(second_i - first_i), 32'd512);

    rst = 1'b0;
    #1;
    check("midrun_rst_led", 32'(bif.led), 32'h0);
    check("midrun_rst_an",  32'(bif.an),  32'hF);
    check("midrun_rst_seg", 32'(bif.seg), 32'h7F);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bif.clk_speed = 3'd0;
    repeat (5) @(negedge clk);

    // Glitch yields no byte; a bad stop bit drops the byte, its good resend completes the word.
    send_word(24'hFF0000);
    bif.UART_rx = 1'b0;
    repeat (5) @(negedge clk);
    bif.UART_rx = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    send_byte(8'hA0, 1'b1);
    send_byte(8'hA1, 1'b1);
    send_byte(8'h80, 1'b0);
    send_byte(8'h80, 1'b1);
    send_word(24'hB01000);
    send_word(24'hF00002);
    send_word(24'hFFFF00);
    repeat (40) @(negedge clk);
    check("framing_led", 32'(bif.led), 32'hA002);

    sync_scan();
    for (int d = 0; d < 4; d++) begin
      check($sformatf("scan_an_%0d", d),  32'(bif.an),  32'(scan[d].an));
      check($sformatf("scan_seg_%0d", d), 32'(bif.seg), 32'(scan[d].seg));
      repeat (16) @(negedge clk);
    end

    // IMEM[2] = F00002 -> low half 0002.
    bif.clk_visual = 1'b1;
    sync_scan();
    check("visual_d0_seg", 32'(bif.seg), 32'h24);
    repeat (16) @(negedge clk);
    check("visual_d1_an",  32'(bif.an),  32'hD);
    check("visual_d1_seg", 32'(bif.seg), 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
